// File: rtl/dma_io_port_if.sv
// DMA I/O-channel bus between the DMA controller (master) and the
// peripheral-side I/O port (slave): request/acknowledge handshake,
// transfer strobes, terminal count and the 8-bit data bus DB.
interface dma_io_port_if #(
  parameter int DATA_W = 8
);
  logic              dreq;
  logic              dack;
  logic              read_io;
  logic              write_io;
  logic              eop;
  logic [DATA_W-1:0] db_in;
  logic [DATA_W-1:0] db_out;
  logic              db_oe;

  modport master (
    input  dreq, db_out, db_oe,
    output dack, read_io, write_io, eop, db_in
  );

  modport slave (
    output dreq, db_out, db_oe,
    input  dack, read_io, write_io, eop, db_in
  );
endinterface

// File: rtl/dma_io_port.sv
// Peripheral-side DMA I/O port: a small FIFO between an I/O device and
// the DMA data bus. mode 00 moves device bytes onto DB (DMA reads the
// port), mode 01 moves DB bytes to the device (DMA writes the port),
// modes 10/11 leave the port idle. One byte per DACK pulse.
module dma_io_port #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode_io,
  input  logic              dev_wr_en,
  input  logic [DATA_W-1:0] dev_wr_data,
  input  logic              dev_rd_en,
  output logic [DATA_W-1:0] dev_rd_data,
  output logic              dev_full,
  output logic              dev_empty,
  dma_io_port_if.slave      dma,
  output logic [PTR_W:0]    count,
  output logic              done,
  output logic              overflow
);

  localparam logic [1:0]     MODE_IN   = 2'b00;  // I/O -> memory
  localparam logic [1:0]     MODE_OUT  = 2'b01;  // memory -> I/O
  localparam logic [PTR_W:0] CNT_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ZERO  = '0;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_mode_q;
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [PTR_W:0]      r_count;
  logic                r_overflow;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_mode_chg;
  logic                w_empty;
  logic                w_full;
  logic                w_want;
  logic                w_oe;
  logic                w_xfer_rd;
  logic                w_xfer_wr;
  logic                w_xfer;
  logic                w_pop;
  logic                w_push_req;
  logic                w_push;
  logic                w_ovf_set;
  logic [DATA_W-1:0]   w_push_data;
  logic                w_dreq;
  logic                w_done;

  assign w_mode_chg = (mode_io != r_mode_q);
  assign w_empty    = (r_count == CNT_ZERO);
  assign w_full     = (r_count == CNT_FULL);

  // A request is worth making when the FIFO can feed or accept a byte.
  assign w_want = ((r_mode_q == MODE_IN)  && !w_empty) ||
                  ((r_mode_q == MODE_OUT) && !w_full);

  // DB is driven for the whole DACK/read_io window, even if the FIFO is empty.
  assign w_oe      = dma.dack && dma.read_io && (r_mode_q == MODE_IN) && (r_state == S_REQ);
  assign w_xfer_rd = w_oe && !w_empty;
  assign w_xfer_wr = dma.dack && dma.write_io && (r_mode_q == MODE_OUT) &&
                     (r_state == S_REQ) && !w_full;
  assign w_xfer    = w_xfer_rd || w_xfer_wr;

  // Pops: DMA read in mode 00, device read in mode 01.
  assign w_pop = (r_mode_q == MODE_IN)  ? w_xfer_rd :
                 (r_mode_q == MODE_OUT) ? (dev_rd_en && !w_empty) : 1'b0;

  // Pushes: device write in mode 00, DMA write in mode 01. A simultaneous
  // pop frees the slot, so a full FIFO still accepts the push then.
  assign w_push_req  = (r_mode_q == MODE_IN)  ? dev_wr_en :
                       (r_mode_q == MODE_OUT) ? w_xfer_wr : 1'b0;
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_ovf_set   = (r_mode_q == MODE_IN) && dev_wr_en && w_full && !w_pop;
  assign w_push_data = (r_mode_q == MODE_IN) ? dev_wr_data : dma.db_in;

  // FSM next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_dreq      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_want) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_dreq = 1'b1;
        if (w_xfer)       w_state_nxt = dma.eop ? S_DONE : S_ACK;
        else if (!w_want) w_state_nxt = S_IDLE;
      end
      S_ACK: begin
        if (!dma.dack) w_state_nxt = S_IDLE;
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_mode_chg) w_state_nxt = S_IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Mode tracking, FIFO pointers/occupancy and the sticky overflow flag;
  // a mode change flushes everything and discards that cycle's traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q   <= MODE_IN;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_mode_q <= mode_io;
      if (w_mode_chg) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push)    r_wptr     <= r_wptr + PTR_ONE;
        if (w_pop)     r_rptr     <= r_rptr + PTR_ONE;
        if (w_ovf_set) r_overflow <= 1'b1;
        r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy governs validity.
  always_ff @(posedge clk) begin
    if (w_push && !w_mode_chg) r_mem[r_wptr] <= w_push_data;
  end

  assign dev_rd_data = r_mem[r_rptr];
  assign dev_full    = w_full;
  assign dev_empty   = w_empty;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign done        = w_done;
  assign dma.dreq    = w_dreq;
  assign dma.db_oe   = w_oe;
  assign dma.db_out  = w_oe ? r_mem[r_rptr] : '0;

endmodule

// File: doc/dma_io_port.md
Name: dma_io_port

Overview:
- Peripheral-side I/O port that sits directly downstream of the DMA controller on its I/O channel.
- Buffers bytes between an I/O device and the 8-bit data bus DB in a small FIFO.
- Raises DREQ and completes one byte per DACK handshake, in the direction selected by mode_io.
- mode_io 00 = I/O->memory (port sources DB); 01 = memory->I/O (port sinks DB); 10/11 = disabled.

Parameters:
DATA_W, 8, data bus / FIFO word width
DEPTH, 4, FIFO entries (power of two)
PTR_W, 2, log2(DEPTH)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mode_io  input  2  transfer direction/enable (see Overview)
dev_wr_en  input  1  device push strobe (mode 00)
dev_wr_data  input  DATA_W  device push data
dev_rd_en  input  1  device pop strobe (mode 01)
dev_rd_data  output  DATA_W  FIFO head, first-word-fall-through
dev_full  output  1  FIFO count == DEPTH
dev_empty  output  1  FIFO count == 0
dreq  output  1  DMA request
dack  input  1  DMA acknowledge
read_io  input  1  DMA reading from port (mode 00 strobe)
write_io  input  1  DMA writing to port (mode 01 strobe)
eop  input  1  DMA terminal count, valid with the transfer strobe
db_in  input  DATA_W  DB value during write_io
db_out  output  DATA_W  value driven onto DB during read_io
db_oe  output  1  DB output enable
count  output  PTR_W+1  FIFO occupancy 0..DEPTH
done  output  1  block transfer finished
overflow  output  1  sticky: device push while full dropped

Behaviour:
Reset:
- state=IDLE, pointers=0, count=0, dreq=0, db_oe=0, done=0, overflow=0.
- dev_empty=1, dev_full=0, db_out=0, mode_q=00.

Mode handling:
- mode_io registered into mode_q each cycle.
- When mode_io != mode_q: FIFO flushed (pointers/count=0), overflow cleared, done cleared, state->IDLE; takes effect at that edge.
- Any push or pop in that cycle is discarded.

Transfer condition xfer:
- dack & read_io & mode_q==00 & state==REQ & count>0, or
- dack & write_io & mode_q==01 & state==REQ & count<DEPTH.

Data path:
- db_oe = dack & read_io & mode_q==00 & state==REQ (combinational).
- db_out = FIFO head when db_oe, else 0.
- mode 00 xfer pops the head; mode 01 xfer pushes db_in.

FSM:
- IDLE: dreq=0. Go to REQ when (mode_q==00 & count>0) or (mode_q==01 & count<DEPTH).
- REQ: dreq=1.
  - xfer & eop -> DONE.
  - xfer & !eop -> ACK.
  - Condition lost (e.g. mode change) -> IDLE.
- ACK: dreq=0; stay until dack=0, then -> IDLE. Guarantees one byte per DACK pulse, minimum 3 cycles/byte.
- DONE: dreq=0, done=1; exit only via mode change or reset.

Device side:
- mode 00: dev_wr_en pushes when count<DEPTH. Push when full is dropped and sets overflow (sticky).
- mode 01: dev_rd_en pops when count>0; pop when empty is ignored, no flag.
- dev_wr_en in mode 01 and dev_rd_en in mode 00 are ignored.

Simultaneous events:
- Device push + DMA pop (mode 00), or DMA push + device pop (mode 01), in the same cycle: both take effect, count unchanged.
- Full + push + pop same cycle: push accepted, no overflow.

Pointers and async behaviour:
- Pointers wrap modulo DEPTH; count saturates by construction.
- dack while state != REQ: ignored, no pointer movement, db_oe=0.
- rst_n low mid-handshake: dreq and db_oe drop immediately (asynchronous).

Test Plan:
- Reset: rst_n=0 -> dreq=0, db_oe=0, count=0, dev_empty=1, done=0. Release, mode_io=10 for 10 cycles -> dreq stays 0.
- I/O->memory: mode_io=00, push 0xA1,0xB2; pulse dack+read_io one cycle per REQ -> db_out 0xA1 then 0xB2 with db_oe=1, dreq low in ACK, count 2->1->0, dreq stays 0 once empty.
- Memory->I/O with eop: mode_io=01, DMA writes 0x11,0x22,0x33, eop on third -> count=3, state DONE, done=1, dreq=0. Device pops -> dev_rd_data 0x11,0x22,0x33.
- Full/overflow: mode_io=00, push 5 bytes 0x01..0x05 -> count=4, dev_full=1, overflow=1, head 0x01. Simultaneous push 0x06 + DMA pop -> count stays 4, overflow unchanged.
- Wrap-around: mode_io=01, 10 interleaved write/pop of 0x00..0x09 -> device reads 0x00..0x09 in order, count never exceeds 4.
- Mode change mid-REQ: count=2 in mode 00, switch to 01 -> next edge count=0, overflow=0, done=0, state IDLE then REQ (space available), dreq=1.
